// File: rtl/alu_cmd_issuer.sv
// Command issuer for a combinational 8-bit ALU: queues operand/opcode commands,
// holds each on the ALU for SETTLE cycles, then returns the tagged 16-bit result.
module alu_cmd_issuer #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [2:0]       cmd_opcode,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [2:0]       alu_opcode,
    output logic             alu_ena,
    input  logic [15:0]      alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_result,
    output logic [2:0]       rsp_opcode,
    output logic [CNT_W-1:0] rsp_seq,
    output logic             busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    state_t           state_q, state_d;
    cmd_t             cmd_mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0] seq_q, seq_d;
    logic [7:0]       alu_a_q, alu_a_d;
    logic [7:0]       alu_b_q, alu_b_d;
    logic [2:0]       alu_opcode_q, alu_opcode_d;
    logic             alu_ena_q, alu_ena_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [15:0]      rsp_result_q, rsp_result_d;
    logic [2:0]       rsp_opcode_q, rsp_opcode_d;
    logic [CNT_W-1:0] rsp_seq_q, rsp_seq_d;

    logic push;
    logic pop;
    cmd_t head;

    // Ready depends on the registered count only: a full FIFO never accepts,
    // even on an edge where the head is popped.
    assign cmd_ready = (count_q < (PTR_W+1)'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    assign head      = cmd_mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            settle_cnt_q <= '0;
            seq_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= '0;
            alu_ena_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_opcode_q <= '0;
            rsp_seq_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            settle_cnt_q <= settle_cnt_d;
            seq_q        <= seq_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opcode_q <= alu_opcode_d;
            alu_ena_q    <= alu_ena_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_opcode_q <= rsp_opcode_d;
            rsp_seq_q    <= rsp_seq_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            cmd_mem_q[wr_ptr_q] <= '{op: cmd_opcode, a: cmd_a, b: cmd_b};
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (pop) state_d = S_SETTLE;
            S_SETTLE: if (settle_cnt_q == '0) state_d = S_RESP;
            S_RESP:   if (rsp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: every _d starts from its _q so no path leaves a latch behind.
    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d      = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        settle_cnt_d = settle_cnt_q;
        seq_d        = seq_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_opcode_d = alu_opcode_q;
        alu_ena_d    = alu_ena_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_opcode_d = rsp_opcode_q;
        rsp_seq_d    = rsp_seq_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    alu_a_d      = head.a;
                    alu_b_d      = head.b;
                    alu_opcode_d = head.op;
                    alu_ena_d    = 1'b1;
                    settle_cnt_d = SET_W'(SETTLE - 1);
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q == '0) begin
                    rsp_result_d = alu_result;
                    rsp_opcode_d = alu_opcode_q;
                    rsp_seq_d    = seq_q;
                    seq_d        = seq_q + CNT_W'(1);
                    alu_ena_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                end else begin
                    settle_cnt_d = settle_cnt_q - SET_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_ena    = alu_ena_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_opcode = rsp_opcode_q;
    assign rsp_seq    = rsp_seq_q;
    assign busy       = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: directed scenarios on a SETTLE=1/CNT_W=2 instance and a
// randomized scoreboard run on a SETTLE=3/DEPTH=2 instance.
module tb_alu_cmd_issuer;

    localparam int DEPTH_A = 4, SETTLE_A = 1, CNT_W_A = 2;
    localparam int DEPTH_B = 2, SETTLE_B = 3, CNT_W_B = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A signals
    logic               cmd_valid, cmd_ready, alu_ena, rsp_valid, rsp_ready, busy;
    logic [7:0]         cmd_a, cmd_b, alu_a, alu_b;
    logic [2:0]         cmd_opcode, alu_opcode, rsp_opcode;
    logic [15:0]        alu_result, rsp_result;
    logic [CNT_W_A-1:0] rsp_seq;
    logic               alu_ovr;
    logic [15:0]        alu_ovr_val;

    // Instance B signals
    logic               b_cmd_valid, b_cmd_ready, b_alu_ena, b_rsp_valid, b_rsp_ready, b_busy;
    logic [7:0]         b_cmd_a, b_cmd_b, b_alu_a, b_alu_b;
    logic [2:0]         b_cmd_opcode, b_alu_opcode, b_rsp_opcode;
    logic [15:0]        b_alu_result, b_rsp_result;
    logic [CNT_W_B-1:0] b_rsp_seq;

    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        case (op)
            3'd0:    return 16'(a) + 16'(b);
            3'd1:    return 16'(a) - 16'(b);
            3'd2:    return 16'(a) * 16'(b);
            3'd3:    return {8'h00, a & b};
            3'd4:    return {8'h00, a | b};
            3'd5:    return {8'h00, a ^ b};
            3'd6:    return {8'h00, ~a};
            default: return {a, b};
        endcase
    endfunction

    assign alu_result   = alu_ovr ? alu_ovr_val : (alu_ena ? alu_f(alu_a, alu_b, alu_opcode) : 16'h0);
    assign b_alu_result = b_alu_ena ? alu_f(b_alu_a, b_alu_b, b_alu_opcode) : 16'h0;

    alu_cmd_issuer #(.DEPTH(DEPTH_A), .SETTLE(SETTLE_A), .CNT_W(CNT_W_A)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opcode(cmd_opcode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_ena(alu_ena),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_opcode(rsp_opcode), .rsp_seq(rsp_seq),
        .busy(busy)
    );

    alu_cmd_issuer #(.DEPTH(DEPTH_B), .SETTLE(SETTLE_B), .CNT_W(CNT_W_B)) dut_b (
        .clk(clk), .rst(rst),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_a(b_cmd_a), .cmd_b(b_cmd_b), .cmd_opcode(b_cmd_opcode),
        .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_opcode(b_alu_opcode), .alu_ena(b_alu_ena),
        .alu_result(b_alu_result),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_result(b_rsp_result), .rsp_opcode(b_rsp_opcode), .rsp_seq(b_rsp_seq),
        .busy(b_busy)
    );

    // Directed command table with hand-computed results and sequence tags (CNT_W=2).
    logic [7:0]  tbl_a   [6] = '{8'h12, 8'h0A, 8'h05, 8'hFF, 8'hF0, 8'h07};
    logic [7:0]  tbl_b   [6] = '{8'h34, 8'h05, 8'h06, 8'hFF, 8'h3C, 8'h09};
    logic [2:0]  tbl_op  [6] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd0};
    logic [15:0] tbl_res [6] = '{16'h0046, 16'h0005, 16'h001E, 16'hFE01, 16'h0030, 16'h0010};
    logic [1:0]  tbl_seq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Offers table entries back-to-back; leaves cmd_valid high if one is still waiting.
    task automatic offer_cmds(input int n, input int budget, output int acc, output int last_cyc);
        bit hs;
        acc      = 0;
        last_cyc = -1;
        for (int cyc = 0; cyc < budget && acc < n; cyc++) begin
            cmd_valid  = 1'b1;
            cmd_a      = tbl_a[acc];
            cmd_b      = tbl_b[acc];
            cmd_opcode = tbl_op[acc];
            hs = cmd_ready;
            step();
            if (hs) begin
                acc++;
                last_cyc = cyc;
            end
        end
        if (acc == n) cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({rsp_valid, alu_ena, busy, cmd_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_ctrl: got valid/ena/busy/ready=%b expected 0001",
                     {rsp_valid, alu_ena, busy, cmd_ready});
        end
        checks++;
        if ({alu_a, alu_b, alu_opcode} !== 19'h0) begin
            failures++;
            $display("FAIL reset_alu: got a=%h b=%h op=%h expected zeros", alu_a, alu_b, alu_opcode);
        end
        checks++;
        if ({rsp_result, rsp_opcode, rsp_seq} !== 21'h0) begin
            failures++;
            $display("FAIL reset_rsp: got res=%h op=%h seq=%h expected zeros",
                     rsp_result, rsp_opcode, rsp_seq);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_add;
        rsp_ready  = 1'b1;
        cmd_a      = 8'h0F;
        cmd_b      = 8'h05;
        cmd_opcode = 3'd0;
        cmd_valid  = 1'b1;
        step();
        cmd_valid = 1'b0;
        checks++;
        if (alu_ena !== 1'b0) begin
            failures++;
            $display("FAIL add_no_bypass: got alu_ena=%b expected 0", alu_ena);
        end
        step();
        checks++;
        if ({alu_ena, rsp_valid, alu_a, alu_b, alu_opcode} !== {1'b1, 1'b0, 8'h0F, 8'h05, 3'd0}) begin
            failures++;
            $display("FAIL add_issue: got ena=%b valid=%b a=%h b=%h op=%h expected 1 0 0f 05 0",
                     alu_ena, rsp_valid, alu_a, alu_b, alu_opcode);
        end
        step();
        checks++;
        if ({rsp_valid, alu_ena, rsp_result, rsp_opcode, rsp_seq} !== {1'b1, 1'b0, 16'h0014, 3'd0, 2'd0}) begin
            failures++;
            $display("FAIL add_rsp: got valid=%b ena=%b res=%h op=%h seq=%h expected 1 0 0014 0 0",
                     rsp_valid, alu_ena, rsp_result, rsp_opcode, rsp_seq);
        end
        step();
        checks++;
        if ({rsp_valid, busy, alu_a, alu_b} !== {1'b0, 1'b0, 8'h0F, 8'h05}) begin
            failures++;
            $display("FAIL add_done: got valid=%b busy=%b a=%h b=%h expected 0 0 0f 05",
                     rsp_valid, busy, alu_a, alu_b);
        end
    endtask

    task automatic test_fill;
        int acc, last_cyc;
        do_reset();
        rsp_ready = 1'b0;
        offer_cmds(6, 12, acc, last_cyc);
        checks++;
        if (acc != 5 || last_cyc != 4) begin
            failures++;
            $display("FAIL fill_accept: got accepted=%0d last_cycle=%0d expected 5 4", acc, last_cyc);
        end
        checks++;
        if ({cmd_ready, busy, rsp_valid} !== 3'b011) begin
            failures++;
            $display("FAIL fill_state: got ready/busy/valid=%b expected 011", {cmd_ready, busy, rsp_valid});
        end
    endtask

    task automatic test_held_response;
        int n = 0;
        int rsp_cyc [6];
        bit hs;
        alu_ovr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            alu_ovr_val = 16'($urandom);
            step();
            checks++;
            if ({rsp_valid, rsp_result, rsp_opcode, rsp_seq} !== {1'b1, tbl_res[0], tbl_op[0], tbl_seq[0]}) begin
                failures++;
                $display("FAIL held_rsp: got valid=%b res=%h op=%h seq=%h expected 1 %h %h %h",
                         rsp_valid, rsp_result, rsp_opcode, rsp_seq, tbl_res[0], tbl_op[0], tbl_seq[0]);
            end
        end
        alu_ovr   = 1'b0;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
            if (rsp_valid) begin
                checks++;
                if ({rsp_result, rsp_opcode, rsp_seq} !== {tbl_res[n], tbl_op[n], tbl_seq[n]}) begin
                    failures++;
                    $display("FAIL drain_rsp%0d: got res=%h op=%h seq=%h expected %h %h %h", n,
                             rsp_result, rsp_opcode, rsp_seq, tbl_res[n], tbl_op[n], tbl_seq[n]);
                end
                rsp_cyc[n] = cyc;
                n++;
            end
            hs = cmd_valid && cmd_ready;
            step();
            if (hs) cmd_valid = 1'b0;
        end
        checks++;
        if (n != 6) begin
            failures++;
            $display("FAIL drain_count: got %0d responses expected 6", n);
        end else begin
            checks++;
            if (rsp_cyc[2] - rsp_cyc[1] != SETTLE_A + 2 || rsp_cyc[3] - rsp_cyc[2] != SETTLE_A + 2) begin
                failures++;
                $display("FAIL throughput: got gaps %0d %0d expected %0d", rsp_cyc[2] - rsp_cyc[1],
                         rsp_cyc[3] - rsp_cyc[2], SETTLE_A + 2);
            end
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL drain_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_op;
        int acc, last_cyc;
        int n = 0;
        do_reset();
        rsp_ready = 1'b0;
        offer_cmds(5, 12, acc, last_cyc);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        step();
        checks++;
        if (alu_ena !== 1'b1) begin
            failures++;
            $display("FAIL midop_settle: got alu_ena=%b expected 1", alu_ena);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({rsp_valid, alu_ena, busy, cmd_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL midop_reset: got valid/ena/busy/ready=%b expected 0001",
                     {rsp_valid, alu_ena, busy, cmd_ready});
        end
        cmd_a      = 8'h0F;
        cmd_b      = 8'h05;
        cmd_opcode = 3'd0;
        cmd_valid  = 1'b1;
        step();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (rsp_valid) begin
                n++;
                checks++;
                if ({rsp_result, rsp_seq} !== {16'h0014, 2'd0}) begin
                    failures++;
                    $display("FAIL midop_rsp: got res=%h seq=%h expected 0014 0", rsp_result, rsp_seq);
                end
            end
            step();
        end
        checks++;
        if (n != 1) begin
            failures++;
            $display("FAIL midop_count: got %0d responses expected 1", n);
        end
    endtask

    task automatic test_seq_wrap;
        logic [20:0] exp_q [$];
        logic [20:0] exp;
        int acc = 0;
        int n = 0;
        do_reset();
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && n < 5; cyc++) begin
            cmd_valid = (acc < 5);
            if (cmd_valid) begin
                cmd_a      = 8'($urandom);
                cmd_b      = 8'($urandom);
                cmd_opcode = 3'($urandom);
            end
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back({alu_f(cmd_a, cmd_b, cmd_opcode), cmd_opcode, 2'(acc)});
                acc++;
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 21'h0;
                if ({rsp_result, rsp_opcode, rsp_seq} !== exp) begin
                    failures++;
                    $display("FAIL wrap_rsp%0d: got %h expected %h", n, {rsp_result, rsp_opcode, rsp_seq}, exp);
                end
                n++;
            end
            step();
        end
        cmd_valid = 1'b0;
        checks++;
        if (n != 5) begin
            failures++;
            $display("FAIL wrap_count: got %0d responses expected 5", n);
        end
    endtask

    task automatic test_random_settle;
        logic [18:0] issue_q [$];
        logic [26:0] rsp_q [$];
        logic [18:0] iss;
        logic [26:0] exp;
        int acc = 0, done = 0, ena_run = 0;
        logic prev_ena = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc < 450) begin
                b_cmd_valid  = ($urandom_range(0, 2) != 0);
                b_rsp_ready  = ($urandom_range(0, 3) != 0);
            end else begin
                b_cmd_valid  = 1'b0;
                b_rsp_ready  = 1'b1;
            end
            b_cmd_a      = 8'($urandom);
            b_cmd_b      = 8'($urandom);
            b_cmd_opcode = 3'($urandom);
            if (b_cmd_valid && b_cmd_ready) begin
                issue_q.push_back({b_cmd_opcode, b_cmd_a, b_cmd_b});
                rsp_q.push_back({alu_f(b_cmd_a, b_cmd_b, b_cmd_opcode), b_cmd_opcode, 8'(acc)});
                acc++;
            end
            if (b_rsp_valid && b_rsp_ready) begin
                checks++;
                exp = (rsp_q.size() > 0) ? rsp_q.pop_front() : 27'h0;
                if ({b_rsp_result, b_rsp_opcode, b_rsp_seq} !== exp) begin
                    failures++;
                    $display("FAIL rand_rsp%0d: got %h expected %h", done,
                             {b_rsp_result, b_rsp_opcode, b_rsp_seq}, exp);
                end
                done++;
            end
            step();
            if (b_alu_ena && !prev_ena) begin
                checks++;
                iss = (issue_q.size() > 0) ? issue_q.pop_front() : 19'h0;
                if ({b_alu_opcode, b_alu_a, b_alu_b} !== iss) begin
                    failures++;
                    $display("FAIL rand_issue: got %h expected %h", {b_alu_opcode, b_alu_a, b_alu_b}, iss);
                end
            end
            if (b_alu_ena) begin
                ena_run++;
            end else if (prev_ena) begin
                checks++;
                if (ena_run != SETTLE_B || b_rsp_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL rand_settle: got ena_cycles=%0d valid=%b expected %0d 1",
                             ena_run, b_rsp_valid, SETTLE_B);
                end
                ena_run = 0;
            end
            prev_ena = b_alu_ena;
            checks++;
            if ((acc - done < DEPTH_B && b_cmd_ready !== 1'b1) || acc - done > DEPTH_B + 1) begin
                failures++;
                $display("FAIL rand_ready: got ready=%b outstanding=%0d limit %0d",
                         b_cmd_ready, acc - done, DEPTH_B + 1);
            end
        end
        checks++;
        if (rsp_q.size() != 0 || b_busy !== 1'b0 || done < 20) begin
            failures++;
            $display("FAIL rand_end: got pending=%0d busy=%b responses=%0d expected 0 0 >=20",
                     rsp_q.size(), b_busy, done);
        end
    endtask

    initial begin
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_a        = '0;
        cmd_b        = '0;
        cmd_opcode   = '0;
        rsp_ready    = 1'b0;
        alu_ovr      = 1'b0;
        alu_ovr_val  = '0;
        b_cmd_valid  = 1'b0;
        b_cmd_a      = '0;
        b_cmd_b      = '0;
        b_cmd_opcode = '0;
        b_rsp_ready  = 1'b0;
        test_reset();
        test_single_add();
        test_fill();
        test_held_response();
        test_reset_mid_op();
        test_seq_wrap();
        test_random_settle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
